// File: rtl/ysyx_axi4_pkg.sv
// Shared AXI4 field widths, burst/response encodings and FSM state types
// for the standalone SRAM slave responder.
package ysyx_axi4_pkg;

   localparam int unsigned ID_W    = 4;
   localparam int unsigned LEN_W   = 8;
   localparam int unsigned SIZE_W  = 3;
   localparam int unsigned BURST_W = 2;
   localparam int unsigned RESP_W  = 2;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned STRB_W  = DATA_W / 8;

   localparam logic [BURST_W-1:0] FIXED = 2'b00;
   localparam logic [BURST_W-1:0] INCR  = 2'b01;
   localparam logic [BURST_W-1:0] WRAP  = 2'b10;

   localparam logic [RESP_W-1:0] OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_DATA
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_t;

endpackage

// File: rtl/ysyx_axi4_burst_addr.sv
// Per-beat address helper: next beat address, memory window test and
// unsupported-burst flag. Purely combinational; one copy per channel.
module ysyx_axi4_burst_addr
   import ysyx_axi4_pkg::*;
#(
   parameter int unsigned       ADDR_W = 32,
   parameter int unsigned       DEPTH  = 1024,
   parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000
) (
   input  logic [ADDR_W-1:0]  addr,
   input  logic [SIZE_W-1:0]  size,
   input  logic [BURST_W-1:0] burst,
   output logic [ADDR_W-1:0]  next_addr,
   output logic               in_range,
   output logic               burst_err
);

   localparam int unsigned SPAN_W = $clog2(DEPTH) + 3;

   logic [ADDR_W-1:0] offset;

   // BASE is aligned to the window size, so any bit above the window
   // offset being set (including wrap-around below BASE) means out of range.
   assign offset    = addr - BASE;
   assign in_range  = (offset >> SPAN_W) == '0;
   assign burst_err = ((burst != FIXED) && (burst != INCR)) || (size > 3'd3);
   assign next_addr = (burst == INCR) ? addr + (ADDR_W'(1) << size) : addr;

endmodule

// File: rtl/ysyx_axi4_sram_slave.sv
// AXI4 slave responder over a 64-bit register-array memory with independent
// read and write FSMs, FIXED/INCR bursts, byte strobes and programmable read latency.
module ysyx_axi4_sram_slave
   import ysyx_axi4_pkg::*;
#(
   parameter int unsigned       ADDR_W = 32,
   parameter int unsigned       DEPTH  = 1024,
   parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
   parameter int unsigned       RD_LAT = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [BURST_W-1:0] io_slave_arburst,
   input  logic [SIZE_W-1:0]  io_slave_arsize,
   input  logic [LEN_W-1:0]   io_slave_arlen,
   input  logic [ID_W-1:0]    io_slave_arid,
   input  logic [ADDR_W-1:0]  io_slave_araddr,
   input  logic               io_slave_arvalid,
   output logic               io_slave_arready,
   output logic [ID_W-1:0]    io_slave_rid,
   output logic               io_slave_rlast,
   output logic [DATA_W-1:0]  io_slave_rdata,
   output logic [RESP_W-1:0]  io_slave_rresp,
   output logic               io_slave_rvalid,
   input  logic               io_slave_rready,
   input  logic [BURST_W-1:0] io_slave_awburst,
   input  logic [SIZE_W-1:0]  io_slave_awsize,
   input  logic [LEN_W-1:0]   io_slave_awlen,
   input  logic [ID_W-1:0]    io_slave_awid,
   input  logic [ADDR_W-1:0]  io_slave_awaddr,
   input  logic               io_slave_awvalid,
   output logic               io_slave_awready,
   input  logic               io_slave_wlast,
   input  logic [DATA_W-1:0]  io_slave_wdata,
   input  logic [STRB_W-1:0]  io_slave_wstrb,
   input  logic               io_slave_wvalid,
   output logic               io_slave_wready,
   output logic [ID_W-1:0]    io_slave_bid,
   output logic [RESP_W-1:0]  io_slave_bresp,
   output logic               io_slave_bvalid,
   input  logic               io_slave_bready
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   rd_state_t          r_state;
   logic [ADDR_W-1:0]  r_addr, r_next;
   logic [LEN_W-1:0]   r_len, r_beat;
   logic [SIZE_W-1:0]  r_size;
   logic [BURST_W-1:0] r_burst;
   logic [3:0]         r_lat;
   logic               r_in, r_berr, r_ok;
   logic [IDX_W-1:0]   r_idx;

   wr_state_t          w_state;
   logic [ADDR_W-1:0]  w_addr, w_next;
   logic [LEN_W-1:0]   w_len, w_beat;
   logic [SIZE_W-1:0]  w_size;
   logic [BURST_W-1:0] w_burst;
   logic               w_err;
   logic               w_in, w_berr, w_ok, w_we;
   logic [IDX_W-1:0]   w_idx;

   ysyx_axi4_burst_addr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) u_rd_addr (
      .addr      (r_addr),
      .size      (r_size),
      .burst     (r_burst),
      .next_addr (r_next),
      .in_range  (r_in),
      .burst_err (r_berr)
   );

   ysyx_axi4_burst_addr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) u_wr_addr (
      .addr      (w_addr),
      .size      (w_size),
      .burst     (w_burst),
      .next_addr (w_next),
      .in_range  (w_in),
      .burst_err (w_berr)
   );

   assign r_ok  = r_in && !r_berr;
   assign r_idx = IDX_W'((r_addr - BASE) >> 3);
   assign w_ok  = w_in && !w_berr;
   assign w_idx = IDX_W'((w_addr - BASE) >> 3);
   assign w_we  = (w_state == W_DATA) && io_slave_wvalid && io_slave_wready && w_ok;

   // Read data comes straight off the array, so a same-cycle write is not yet visible.
   assign io_slave_rdata = (io_slave_rvalid && r_ok) ? mem[r_idx] : '0;
   assign io_slave_rresp = (io_slave_rvalid && !r_ok) ? SLVERR : OKAY;
   assign io_slave_rlast = io_slave_rvalid && (r_beat == r_len);
   assign io_slave_bresp = (io_slave_bvalid && w_err) ? SLVERR : OKAY;

   always_ff @(posedge clock) begin
      if (w_we) begin
         for (int i = 0; i < int'(STRB_W); i++) begin
            if (io_slave_wstrb[i]) mem[w_idx][8*i +: 8] <= io_slave_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state          <= R_IDLE;
         io_slave_arready <= 1'b0;
         io_slave_rvalid  <= 1'b0;
         io_slave_rid     <= '0;
         r_addr           <= '0;
         r_len            <= '0;
         r_beat           <= '0;
         r_size           <= '0;
         r_burst          <= '0;
         r_lat            <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (io_slave_arvalid && io_slave_arready) begin
                  io_slave_arready <= 1'b0;
                  io_slave_rid     <= io_slave_arid;
                  r_addr           <= io_slave_araddr;
                  r_len            <= io_slave_arlen;
                  r_size           <= io_slave_arsize;
                  r_burst          <= io_slave_arburst;
                  r_beat           <= '0;
                  r_lat            <= 4'(RD_LAT);
                  if (RD_LAT == 0) begin
                     r_state         <= R_DATA;
                     io_slave_rvalid <= 1'b1;
                  end else begin
                     r_state <= R_WAIT;
                  end
               end else begin
                  io_slave_arready <= 1'b1;
               end
            end
            R_WAIT: begin
               if (r_lat <= 4'd1) begin
                  r_state         <= R_DATA;
                  io_slave_rvalid <= 1'b1;
               end else begin
                  r_lat <= r_lat - 4'd1;
               end
            end
            R_DATA: begin
               if (io_slave_rready) begin
                  r_addr <= r_next;
                  r_beat <= r_beat + 8'd1;
                  if (r_beat == r_len) begin
                     r_state          <= R_IDLE;
                     io_slave_rvalid  <= 1'b0;
                     io_slave_arready <= 1'b1;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         w_state          <= W_IDLE;
         io_slave_awready <= 1'b0;
         io_slave_wready  <= 1'b0;
         io_slave_bvalid  <= 1'b0;
         io_slave_bid     <= '0;
         w_addr           <= '0;
         w_len            <= '0;
         w_beat           <= '0;
         w_size           <= '0;
         w_burst          <= '0;
         w_err            <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (io_slave_awvalid && io_slave_awready) begin
                  io_slave_awready <= 1'b0;
                  io_slave_wready  <= 1'b1;
                  io_slave_bid     <= io_slave_awid;
                  w_addr           <= io_slave_awaddr;
                  w_len            <= io_slave_awlen;
                  w_size           <= io_slave_awsize;
                  w_burst          <= io_slave_awburst;
                  w_beat           <= '0;
                  w_err            <= 1'b0;
                  w_state          <= W_DATA;
               end else begin
                  io_slave_awready <= 1'b1;
               end
            end
            W_DATA: begin
               if (io_slave_wvalid && io_slave_wready) begin
                  w_addr <= w_next;
                  w_beat <= w_beat + 8'd1;
                  // Dropped beats and a wlast that disagrees with the beat count both flag SLVERR.
                  if (!w_ok || (io_slave_wlast != (w_beat == w_len))) w_err <= 1'b1;
                  if (io_slave_wlast || (w_beat == w_len)) begin
                     w_state         <= W_RESP;
                     io_slave_wready <= 1'b0;
                     io_slave_bvalid <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (io_slave_bready) begin
                  w_state          <= W_IDLE;
                  io_slave_bvalid  <= 1'b0;
                  io_slave_awready <= 1'b1;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_axi4_sram_slave.sv
// Bench for ysyx_axi4_sram_slave: table of single-beat write/read vectors plus
// hand-written burst, error, wlast and reset sequences, checked through R/B scoreboards.
module tb_ysyx_axi4_sram_slave;

   localparam int unsigned TB_RD_LAT = 1;
   localparam logic [1:0] B_FIXED = 2'b00, B_INCR = 2'b01, B_WRAP = 2'b10, B_RSVD = 2'b11;
   localparam logic [1:0] R_OK = 2'b00, R_SLV = 2'b10;

   logic        clock, reset;
   logic [1:0]  io_slave_arburst, io_slave_awburst;
   logic [2:0]  io_slave_arsize, io_slave_awsize;
   logic [7:0]  io_slave_arlen, io_slave_awlen;
   logic [3:0]  io_slave_arid, io_slave_awid, io_slave_rid, io_slave_bid;
   logic [31:0] io_slave_araddr, io_slave_awaddr;
   logic        io_slave_arvalid, io_slave_arready, io_slave_rlast, io_slave_rvalid, io_slave_rready;
   logic [63:0] io_slave_rdata, io_slave_wdata;
   logic [1:0]  io_slave_rresp, io_slave_bresp;
   logic        io_slave_awvalid, io_slave_awready, io_slave_wlast, io_slave_wvalid, io_slave_wready;
   logic [7:0]  io_slave_wstrb;
   logic        io_slave_bvalid, io_slave_bready;

   ysyx_axi4_sram_slave #(.ADDR_W(32), .DEPTH(1024), .BASE(32'h8000_0000), .RD_LAT(TB_RD_LAT)) dut (
      .clock(clock), .reset(reset),
      .io_slave_arburst(io_slave_arburst), .io_slave_arsize(io_slave_arsize),
      .io_slave_arlen(io_slave_arlen), .io_slave_arid(io_slave_arid),
      .io_slave_araddr(io_slave_araddr), .io_slave_arvalid(io_slave_arvalid),
      .io_slave_arready(io_slave_arready), .io_slave_rid(io_slave_rid),
      .io_slave_rlast(io_slave_rlast), .io_slave_rdata(io_slave_rdata),
      .io_slave_rresp(io_slave_rresp), .io_slave_rvalid(io_slave_rvalid),
      .io_slave_rready(io_slave_rready), .io_slave_awburst(io_slave_awburst),
      .io_slave_awsize(io_slave_awsize), .io_slave_awlen(io_slave_awlen),
      .io_slave_awid(io_slave_awid), .io_slave_awaddr(io_slave_awaddr),
      .io_slave_awvalid(io_slave_awvalid), .io_slave_awready(io_slave_awready),
      .io_slave_wlast(io_slave_wlast), .io_slave_wdata(io_slave_wdata),
      .io_slave_wstrb(io_slave_wstrb), .io_slave_wvalid(io_slave_wvalid),
      .io_slave_wready(io_slave_wready), .io_slave_bid(io_slave_bid),
      .io_slave_bresp(io_slave_bresp), .io_slave_bvalid(io_slave_bvalid),
      .io_slave_bready(io_slave_bready)
   );

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [7:0]  strb;
      logic [63:0] wdata;
      logic [1:0]  bresp;
      logic [63:0] rdata;
      logic [1:0]  rresp;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } exp_r_t;

   typedef struct {
      logic [3:0] id;
      logic [1:0] resp;
   } exp_b_t;

   vec_t        vt [11];
   exp_r_t      rq [$];
   exp_b_t      bq [$];
   logic [63:0] wbuf [16];
   logic [7:0]  sbuf [16];
   int          n_chk = 0;
   int          n_pass = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tmo(input string name);
      n_chk++;
      $display("FAIL %s: handshake not seen within bound, required one", name);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int nbeats,
                           input int last_beat);
      bit     ok;
      exp_b_t e;
      io_slave_awaddr  = addr;
      io_slave_awlen   = len;
      io_slave_awsize  = size;
      io_slave_awburst = burst;
      io_slave_awid    = id;
      io_slave_awvalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         ok = io_slave_awready;
         @(posedge clock); #1;
      end
      io_slave_awvalid = 1'b0;
      if (!ok) tmo("aw_handshake");
      for (int b = 0; b < nbeats; b++) begin
         io_slave_wvalid = 1'b1;
         io_slave_wdata  = wbuf[b];
         io_slave_wstrb  = sbuf[b];
         io_slave_wlast  = (b == last_beat);
         ok = 1'b0;
         for (int c = 0; c < 50 && !ok; c++) begin
            ok = io_slave_wready;
            @(posedge clock); #1;
         end
         if (!ok) tmo("w_handshake");
      end
      io_slave_wvalid = 1'b0;
      io_slave_wlast  = 1'b0;
      io_slave_bready = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         if (io_slave_bvalid) ok = 1'b1;
         else begin
            @(posedge clock); #1;
         end
      end
      if (!ok) tmo("b_handshake");
      else if (bq.size() == 0) tmo("b_unexpected");
      else begin
         e = bq.pop_front();
         chk("bid", 64'(io_slave_bid), 64'(e.id));
         chk("bresp", 64'(io_slave_bresp), 64'(e.resp));
         @(posedge clock); #1;
      end
      io_slave_bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input bit toggle);
      bit     ok, prev_stall, seen;
      int     got;
      exp_r_t e;
      io_slave_araddr  = addr;
      io_slave_arlen   = len;
      io_slave_arsize  = size;
      io_slave_arburst = burst;
      io_slave_arid    = id;
      io_slave_arvalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         ok = io_slave_arready;
         @(posedge clock); #1;
      end
      io_slave_arvalid = 1'b0;
      if (!ok) tmo("ar_handshake");
      got = 0;
      prev_stall = 1'b0;
      seen = 1'b0;
      io_slave_rready = 1'b0;
      for (int c = 0; c < 200 && got <= int'(len); c++) begin
         io_slave_rready = toggle ? ~io_slave_rready : 1'b1;
         if (prev_stall) chk("rvalid_hold", 64'(io_slave_rvalid), 64'd1);
         if (io_slave_rvalid && !seen) begin
            seen = 1'b1;
            chk("rd_latency", 64'(c), 64'(TB_RD_LAT));
         end
         if (io_slave_rvalid && io_slave_rready) begin
            if (rq.size() == 0) tmo("r_unexpected");
            else begin
               e = rq.pop_front();
               chk("rdata", io_slave_rdata, e.data);
               chk("rresp", 64'(io_slave_rresp), 64'(e.resp));
               chk("rlast", 64'(io_slave_rlast), 64'(e.last));
               chk("rid", 64'(io_slave_rid), 64'(e.id));
            end
            got++;
         end
         prev_stall = io_slave_rvalid && !io_slave_rready;
         @(posedge clock); #1;
      end
      io_slave_rready = 1'b0;
      if (got <= int'(len)) tmo("r_beats");
      chk("r_done_rvalid", 64'(io_slave_rvalid), 64'd0);
      chk("r_done_arready", 64'(io_slave_arready), 64'd1);
   endtask

   initial begin
      bit ok;
      int got;
      reset = 1'b1;
      {io_slave_arburst, io_slave_arsize, io_slave_arlen, io_slave_arid, io_slave_araddr} = '0;
      {io_slave_awburst, io_slave_awsize, io_slave_awlen, io_slave_awid, io_slave_awaddr} = '0;
      {io_slave_arvalid, io_slave_awvalid, io_slave_wvalid, io_slave_wlast} = '0;
      {io_slave_rready, io_slave_bready, io_slave_wdata, io_slave_wstrb} = '0;

      vt[0]  = '{32'h8000_0010, 3'd3, B_INCR, 8'hFF, 64'h1122_3344_5566_7788, R_OK, 64'h1122_3344_5566_7788, R_OK};
      vt[1]  = '{32'h8000_0020, 3'd3, B_INCR, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, R_OK, 64'hFFFF_FFFF_FFFF_FFFF, R_OK};
      vt[2]  = '{32'h8000_0022, 3'd0, B_INCR, 8'h04, 64'h0000_0000_00AB_0000, R_OK, 64'hFFFF_FFFF_FFAB_FFFF, R_OK};
      vt[3]  = '{32'h8000_0028, 3'd3, B_INCR, 8'hFF, 64'h0123_4567_89AB_CDEF, R_OK, 64'h0123_4567_89AB_CDEF, R_OK};
      vt[4]  = '{32'h8000_002C, 3'd2, B_INCR, 8'hF0, 64'hDEAD_BEEF_0000_0000, R_OK, 64'hDEAD_BEEF_89AB_CDEF, R_OK};
      vt[5]  = '{32'h8000_2000, 3'd3, B_INCR, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, R_SLV, 64'h0, R_SLV};
      vt[6]  = '{32'h7FFF_FFF8, 3'd3, B_INCR, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, R_SLV, 64'h0, R_SLV};
      vt[7]  = '{32'h8000_0010, 3'd3, B_WRAP, 8'hFF, 64'h0, R_SLV, 64'h0, R_SLV};
      vt[8]  = '{32'h8000_0010, 3'd3, B_INCR, 8'h00, 64'h0, R_OK, 64'h1122_3344_5566_7788, R_OK};
      vt[9]  = '{32'h8000_0030, 3'd4, B_INCR, 8'hFF, 64'h0, R_SLV, 64'h0, R_SLV};
      vt[10] = '{32'h8000_0030, 3'd3, B_RSVD, 8'hFF, 64'h0, R_SLV, 64'h0, R_SLV};

      #3 reset = 1'b0;
      #9;
      chk("rst_arready", 64'(io_slave_arready), 64'd0);
      chk("rst_awready", 64'(io_slave_awready), 64'd0);
      chk("rst_wready", 64'(io_slave_wready), 64'd0);
      chk("rst_rvalid", 64'(io_slave_rvalid), 64'd0);
      chk("rst_bvalid", 64'(io_slave_bvalid), 64'd0);
      chk("rst_rid_rdata_rresp", {54'(io_slave_rid), io_slave_rresp, 8'h0} | io_slave_rdata, 64'd0);
      chk("rst_bid_bresp", 64'({io_slave_bid, io_slave_bresp}), 64'd0);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1;
      chk("idle_arready", 64'(io_slave_arready), 64'd1);
      chk("idle_awready", 64'(io_slave_awready), 64'd1);

      for (int i = 0; i < 11; i++) begin
         wbuf[0] = vt[i].wdata;
         sbuf[0] = vt[i].strb;
         bq.push_back('{4'(i), vt[i].bresp});
         do_write(vt[i].addr, 8'd0, vt[i].size, vt[i].burst, 4'(i), 1, 0);
         rq.push_back('{vt[i].rdata, vt[i].rresp, 1'b1, 4'(15 - i)});
         do_read(vt[i].addr, 8'd0, vt[i].size, vt[i].burst, 4'(15 - i), 1'b0);
      end

      // INCR burst, read back with rready toggling every cycle
      for (int b = 0; b < 4; b++) begin
         wbuf[b] = 64'(b);
         sbuf[b] = 8'hFF;
      end
      bq.push_back('{4'd5, R_OK});
      do_write(32'h8000_0000, 8'd3, 3'd3, B_INCR, 4'd5, 4, 3);
      for (int b = 0; b < 4; b++) rq.push_back('{64'(b), R_OK, (b == 3), 4'd6});
      do_read(32'h8000_0000, 8'd3, 3'd3, B_INCR, 4'd6, 1'b1);

      // INCR burst crossing the top of the window
      wbuf[0] = 64'hA0A0_A0A0_0000_0001;
      wbuf[1] = 64'hB0B0_B0B0_0000_0002;
      sbuf[0] = 8'hFF;
      sbuf[1] = 8'hFF;
      bq.push_back('{4'd7, R_SLV});
      do_write(32'h8000_1FF8, 8'd1, 3'd3, B_INCR, 4'd7, 2, 1);
      rq.push_back('{64'hA0A0_A0A0_0000_0001, R_OK, 1'b0, 4'd8});
      rq.push_back('{64'h0, R_SLV, 1'b1, 4'd8});
      do_read(32'h8000_1FF8, 8'd1, 3'd3, B_INCR, 4'd8, 1'b0);

      // early wlast: two of four beats land, response is SLVERR
      wbuf[0] = 64'h55;
      wbuf[1] = 64'h66;
      bq.push_back('{4'd9, R_SLV});
      do_write(32'h8000_0040, 8'd3, 3'd3, B_INCR, 4'd9, 2, 1);
      rq.push_back('{64'h55, R_OK, 1'b0, 4'd1});
      rq.push_back('{64'h66, R_OK, 1'b1, 4'd1});
      do_read(32'h8000_0040, 8'd1, 3'd3, B_INCR, 4'd1, 1'b0);

      // missing wlast on the final beat
      wbuf[0] = 64'h77;
      bq.push_back('{4'd2, R_SLV});
      do_write(32'h8000_0050, 8'd0, 3'd3, B_INCR, 4'd2, 1, -1);
      rq.push_back('{64'h77, R_OK, 1'b1, 4'd3});
      do_read(32'h8000_0050, 8'd0, 3'd3, B_INCR, 4'd3, 1'b0);

      // FIXED burst keeps hitting the same word
      wbuf[0] = 64'hAA;
      wbuf[1] = 64'hBB;
      bq.push_back('{4'd4, R_OK});
      do_write(32'h8000_0060, 8'd1, 3'd3, B_FIXED, 4'd4, 2, 1);
      rq.push_back('{64'hBB, R_OK, 1'b0, 4'd5});
      rq.push_back('{64'hBB, R_OK, 1'b1, 4'd5});
      do_read(32'h8000_0060, 8'd1, 3'd3, B_FIXED, 4'd5, 1'b0);

      // reset during beat 2 of an 8-beat read
      for (int b = 0; b < 8; b++) begin
         wbuf[b] = 64'h100 + 64'(b);
         sbuf[b] = 8'hFF;
      end
      bq.push_back('{4'd3, R_OK});
      do_write(32'h8000_0080, 8'd7, 3'd3, B_INCR, 4'd3, 8, 7);
      io_slave_araddr  = 32'h8000_0080;
      io_slave_arlen   = 8'd7;
      io_slave_arsize  = 3'd3;
      io_slave_arburst = B_INCR;
      io_slave_arid    = 4'd12;
      io_slave_arvalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         ok = io_slave_arready;
         @(posedge clock); #1;
      end
      io_slave_arvalid = 1'b0;
      if (!ok) tmo("rst_ar_handshake");
      io_slave_rready = 1'b1;
      got = 0;
      for (int c = 0; c < 50 && got < 2; c++) begin
         if (io_slave_rvalid) begin
            chk("rst_burst_rdata", io_slave_rdata, 64'h100 + 64'(got));
            got++;
         end
         @(posedge clock); #1;
      end
      if (got < 2) tmo("rst_burst_beats");
      chk("rst_beat2_rvalid", 64'(io_slave_rvalid), 64'd1);
      chk("rst_beat2_rdata", io_slave_rdata, 64'h102);
      io_slave_rready = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_mid_rvalid", 64'(io_slave_rvalid), 64'd0);
      chk("rst_mid_arready", 64'(io_slave_arready), 64'd0);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1;
      chk("rst_after_arready", 64'(io_slave_arready), 64'd1);
      chk("rst_after_rvalid", 64'(io_slave_rvalid), 64'd0);
      rq.push_back('{64'h101, R_OK, 1'b1, 4'd9});
      do_read(32'h8000_0088, 8'd0, 3'd3, B_INCR, 4'd9, 1'b0);

      chk("r_scoreboard_empty", 64'(rq.size()), 64'd0);
      chk("b_scoreboard_empty", 64'(bq.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ysyx_axi4_sram_slave.md
Name: ysyx_axi4_sram_slave

Overview:
AXI4 slave responder backed by an internal 64-bit-wide register-array memory. It is the memory-side end of the core's io_master_* AXI4 interface and is intended for standalone bus bring-up and unit tests without the SoC. Read and write channels run as independent FSMs. The block supports FIXED and INCR bursts, narrow transfers and byte strobes, with a programmable read latency.

Parameters:
ADDR_W, 32, address width (matches core ADDR_W).
DEPTH, 1024, number of 64-bit memory words; must be a power of two.
BASE, 32'h8000_0000, byte address of word 0; must be aligned to 8*DEPTH.
RD_LAT, 1, cycles from AR handshake to first rvalid; range 0..15.

Ports:
clock  in  1  single clock, all state on posedge.
reset  in  1  asynchronous active-low reset (0 = in reset).
io_slave_arburst/arsize/arlen/arid  in  2/3/8/4  AR channel burst type, size, beats-1, ID.
io_slave_araddr  in  ADDR_W  read start byte address.
io_slave_arvalid / io_slave_arready  in/out  1  AR handshake.
io_slave_rid/rlast/rdata/rresp  out  4/1/64/2  R channel ID, last beat, data, response.
io_slave_rvalid / io_slave_rready  out/in  1  R handshake.
io_slave_awburst/awsize/awlen/awid  in  2/3/8/4  AW channel burst type, size, beats-1, ID.
io_slave_awaddr  in  ADDR_W  write start byte address.
io_slave_awvalid / io_slave_awready  in/out  1  AW handshake.
io_slave_wlast/wdata/wstrb  in  1/64/8  W channel last beat, data, byte strobe.
io_slave_wvalid / io_slave_wready  in/out  1  W handshake.
io_slave_bid/bresp  out  4/2  B channel ID, response.
io_slave_bvalid / io_slave_bready  out/in  1  B handshake.

Behaviour:
- Reset (async assert, sync-safe deassert): both FSMs go to IDLE. All valid/ready outputs are 0. rid, rdata, rresp, bid and bresp are 0. Memory contents are not reset.
- Reset mid-burst: the burst is abandoned silently. No further R beats or B response are issued for it.
- Read FSM states:
  - R_IDLE: arready=1. On arvalid&arready, capture id, addr, len, size and burst; set beat=0 and lat=RD_LAT. Go to R_DATA if RD_LAT=0, else R_WAIT.
  - R_WAIT: arready=0. lat decrements each cycle; go to R_DATA when lat reaches 1.
  - R_DATA: rvalid=1. rdata = mem[(addr-BASE)>>3], full 64-bit word with no lane shifting. rid = captured id. rlast = (beat==len). On rready, advance addr and increment beat. If rlast, return to R_IDLE next cycle. Subsequent beats are back-to-back.
- Write FSM states:
  - W_IDLE: awready=1. On awvalid&awready, capture fields and set beat=0, err=0. Go to W_DATA.
  - W_DATA: wready=1. On wvalid, each byte i with wstrb[i]=1 is written into the addressed word, effective next cycle; then advance addr and increment beat. Leave to W_RESP when wlast=1 or beat==len.
  - W_RESP: bvalid=1, bid = captured id, bresp = err ? 2'b10 : 2'b00. On bready, return to W_IDLE.
- Address advance: INCR adds (1<<size) and wraps modulo 2^ADDR_W. FIXED holds the address.
- SLVERR (2'b10) conditions:
  - Any beat whose address lies outside [BASE, BASE+8*DEPTH). For reads, rdata=0. For writes, the beat is dropped and err is set.
  - Burst type WRAP or reserved (2'b10, 2'b11): every beat errors with no memory access.
  - size>3: every beat errors with no memory access.
  - An INCR burst crossing the top of the range errors only on the out-of-range beats.
- wlast mismatch sets err:
  - Early wlast (beat<len): the burst ends at that beat.
  - Missing wlast at beat==len: the burst ends anyway.
- Read/write concurrency: the channels are fully independent. A read of a word being written in the same cycle returns the old data.
- Handshakes: valid is never withdrawn before the matching ready. arready=0 outside R_IDLE; awready=0 outside W_IDLE. Only one outstanding transaction per channel.

Decomposition:
- Package ysyx_axi4_pkg holds:
  - Burst constants: FIXED=2'b00, INCR=2'b01, WRAP=2'b10.
  - Response constants: OKAY=2'b00, SLVERR=2'b10.
  - rd_state_t and wr_state_t enums.
  - Shared AXI field widths.
- Sub-module ysyx_axi4_burst_addr is combinational: inputs addr, size, burst; outputs next_addr, in_range and burst_err. It is instantiated once for the read FSM and once for the write FSM.

Test Plan:
- Single write then read: AW addr=0x8000_0010, len=0, size=3, wdata=0x1122334455667788, wstrb=0xFF; then AR same address. Expect bresp=0, then after RD_LAT cycles rvalid with rdata=0x1122334455667788, rlast=1, rresp=0, and ids echoed.
- INCR burst with backpressure: write 4 beats from 0x8000_0000, size=3, data 0..3; read back with len=3 while toggling rready every cycle. Expect rdata 0,1,2,3 in order, rlast only on beat 3, rvalid held while rready=0.
- Strobe/narrow merge: word preloaded to 0xFFFF_FFFF_FFFF_FFFF; write size=0, wstrb=0x04, wdata=0x0000_0000_00AB_0000. Expect readback 0xFFFF_FFFF_FFAB_FFFF.
- Errors:
  - AR at BASE+8*DEPTH expects rresp=2'b10, rdata=0.
  - awburst=WRAP expects bresp=2'b10 and memory unchanged.
  - INCR len=1 starting at the last word expects beat0 OKAY, beat1 SLVERR.
- wlast mismatch: awlen=3 with wlast asserted on beat 1. Expect the B response after 2 beats with bresp=2'b10, and both beats written.
- Reset mid-burst: assert reset during beat 2 of an 8-beat read. Expect rvalid=0 immediately, arready=1 after deassert, and a new single read returning correct data.
